// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button conditioner.
// Synchronizes and debounces the raw button, emits one ped_req pulse per
// pedestrian service, drives the WAIT lamp until walk starts, and holds a
// lockout after each walk so a held or bouncing button cannot re-trigger.
module ped_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_raw,
  input  logic       ped_walk,
  output logic       ped_req,
  output logic       req_pending,
  output logic [7:0] press_count
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    QUAL       = 3'd1,
    WAIT_SERVE = 3'd2,
    SERVING    = 3'd3,
    LOCKOUT    = 3'd4
  } state_t;

  // Terminal values of the two counters.
  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT_CYCLES - 1);

  state_t     state_reg;
  logic [7:0] deb_cnt_reg;
  logic [7:0] lock_cnt_reg;
  logic       btn_meta_reg;
  logic       btn_s;

  // Two-flop synchronizer; only btn_s is used by the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_reg <= 1'b0;
      btn_s        <= 1'b0;
    end else begin
      btn_meta_reg <= btn_raw;
      btn_s        <= btn_meta_reg;
    end
  end

  // Request FSM with registered outputs. ped_req and req_pending are set
  // on the same edge that enters WAIT_SERVE, so they line up with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      deb_cnt_reg  <= 8'd0;
      lock_cnt_reg <= 8'd0;
      ped_req      <= 1'b0;
      req_pending  <= 1'b0;
      press_count  <= 8'd0;
    end else begin
      // ped_req is a single-cycle pulse unless re-armed below.
      ped_req <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (btn_s) begin
            state_reg   <= QUAL;
            deb_cnt_reg <= 8'd1;
          end
        end

        QUAL: begin
          if (!btn_s) begin
            // Any low sample restarts qualification.
            state_reg   <= IDLE;
            deb_cnt_reg <= 8'd0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            state_reg   <= WAIT_SERVE;
            deb_cnt_reg <= 8'd0;
            ped_req     <= 1'b1;
            req_pending <= 1'b1;
            if (press_count != 8'hFF) begin
              press_count <= press_count + 8'd1;
            end
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 8'd1;
          end
        end

        WAIT_SERVE: begin
          // Button activity is ignored while the request is outstanding.
          if (ped_walk) begin
            state_reg   <= SERVING;
            req_pending <= 1'b0;
          end
        end

        SERVING: begin
          if (!ped_walk) begin
            state_reg    <= LOCKOUT;
            lock_cnt_reg <= 8'd0;
          end
        end

        LOCKOUT: begin
          // Count up and hold at the end; a still-held button keeps us here.
          if (lock_cnt_reg != LOCK_LAST) begin
            lock_cnt_reg <= lock_cnt_reg + 8'd1;
          end else if (!btn_s) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg    <= IDLE;
          deb_cnt_reg  <= 8'd0;
          lock_cnt_reg <= 8'd0;
          req_pending  <= 1'b0;
        end
      endcase
    end
  end

endmodule
